// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one valid/ready load/store request becomes one
// single-beat Wishbone cycle. The result comes back on a response port that is
// held until it is consumed. The block does lane select, write-data
// replication, read extract with sign/zero extension, a misalignment check and
// a bus timeout.
module wb_initiator #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [31:0]           dat_o,
    input  logic [31:0]           dat_i,
    output logic                  we_o,
    output logic [3:0]            sel_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    // Counter only needs to reach TIMEOUT_CYCLES-1 before the cycle is abandoned
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0]           lane;
    logic [31:0]           load_val;
    logic                  misaligned;

    // Next-state, request capture and response formation
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        lane     = dat_i >> {off_q, 3'b000};
        load_val = dat_i;
        case (size_q)
            2'd0:    load_val = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_val = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = dat_i;
        endcase

        misaligned = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    adr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    case (req_size)
                        2'd0: begin
                            sel_d  = 4'b0001 << req_addr[1:0];
                            wdat_d = {4{req_wdata[7:0]}};
                        end
                        2'd1: begin
                            sel_d  = 4'b0011 << req_addr[1:0];
                            wdat_d = {2{req_wdata[15:0]}};
                        end
                        default: begin
                            sel_d  = 4'b1111;
                            wdat_d = req_wdata;
                        end
                    endcase
                    if (!req_we) begin
                        wdat_d = '0;
                    end
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // Error outranks a simultaneous ack; ack outranks a timeout on the last cycle
                if (err_i) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (ack_i) begin
                    rdata_d = we_q ? 32'd0 : load_val;
                    state_d = RESP;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign cyc_o     = (state_q == BUS);
    assign stb_o     = (state_q == BUS);
    assign adr_o     = adr_q;
    assign dat_o     = wdat_q;
    assign we_o      = we_q;
    assign sel_o     = sel_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
